uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000: system clock frequency, Hz.
REQ-002 Parameter BAUD_RATE, default 115_200: serial bit rate, baud.
REQ-003 Derived DIVIDER = CLK_FREQ / BAUD_RATE (integer division), HALF = DIVIDER / 2; DIVIDER SHALL be in 4..65535, else elaboration error.
REQ-004 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_data  output  8  last correctly framed byte; held until the next valid frame.
REQ-008 o_valid  output  1  one-cycle pulse: o_data updated this cycle.
REQ-009 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 o_busy  output  1  high whenever state is not S_IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rx_s only.
REQ-012 States: S_IDLE, S_START, S_DATA, S_STOP, S_BREAK; one 16-bit clock counter, 3-bit bit index, 8-bit shift register.
REQ-013 S_IDLE: counter = 0, index = 0; rx_s == 0 -> S_START.
REQ-014 S_START: count 0..HALF-1; at HALF-1 sample rx_s: 0 -> S_DATA, counter 0; 1 -> S_IDLE (false start, no output pulse).
REQ-015 S_DATA: count 0..DIVIDER-1; at DIVIDER-1 store rx_s into shift bit [index], counter 0; index 7 -> S_STOP, else index+1.
REQ-016 S_STOP: count 0..DIVIDER-1; at DIVIDER-1 sample rx_s.
REQ-017 Stop sample 1: o_data <= shift register, o_valid = 1 for exactly that cycle, -> S_IDLE (mid-stop-bit, ready for next start edge).
REQ-018 Stop sample 0: o_frame_err = 1 for one cycle, o_data unchanged, -> S_BREAK.
REQ-019 S_BREAK: remain until rx_s == 1, then -> S_IDLE; no output pulses while in S_BREAK.
REQ-020 o_valid and o_frame_err SHALL never be high in the same cycle; neither is high outside the stop-sample cycle.
REQ-021 Latency: o_valid rises 9*DIVIDER + HALF + 3 cycles (+/-1) after the i_rx falling edge of the start bit.
REQ-022 Back-to-back frames (stop bit immediately followed by next start) SHALL be received without loss.
REQ-023 Low glitch on i_rx shorter than HALF cycles SHALL be rejected as false start.
REQ-024 Invalid state encoding -> S_IDLE on next clock.
REQ-025 o_busy combinational from state; all other outputs registered.

Reset
REQ-026 rst_n low: state S_IDLE, counter 0, index 0, shift 0, o_data 0x00, o_valid 0, o_frame_err 0, synchronizer flops 1, immediately and asynchronously.
REQ-027 Reset mid-frame SHALL discard the partial byte; after release, reception restarts only on a new falling edge.
REQ-028 i_rx held low through reset release -> normal start detection, frame error at stop, then S_BREAK until line high.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000: DIVIDER=10, HALF=5)
REQ-029 Frame 0xA5 with valid stop -> single o_valid pulse, o_data=0xA5, o_frame_err never high, latency 98 +/-1 cycles.
REQ-030 Frames 0x00, 0xFF, 0x55 back-to-back, no idle gap -> three o_valid pulses carrying 0x00, 0xFF, 0x55 in order.
REQ-031 3-cycle low glitch on idle line -> no o_valid, no o_frame_err, o_busy back low within 8 cycles.
REQ-032 Frame 0x3C with stop bit forced low, line kept low 30 cycles -> one o_frame_err pulse, o_data unchanged, o_busy high until line returns high, then frame 0x81 -> o_data=0x81.
REQ-033 rst_n asserted during data bit 4 of frame 0x7E -> all outputs at reset values instantly; next complete frame 0x12 -> o_data=0x12.
REQ-034 Loopback with the team's transmitter (default parameters), 256 random bytes -> every byte received exactly once, in order, no frame errors.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. The serial line is synchronised, the start
// bit is qualified at its midpoint, and data and stop bits are then sampled
// once per bit period from that midpoint. A low stop bit raises a one-cycle
// frame error, and the receiver then waits for the line to return high.
module uart_rx #(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_busy
);

   localparam int DIVIDER = CLK_FREQ / BAUD_RATE;
   localparam int HALF    = DIVIDER / 2;

   // The counter is 16 bits wide and the half-bit wait must be at least two
   // cycles, so the bit period is limited to 4..65535 clocks.
   generate
      if ((DIVIDER < 4) || (DIVIDER > 65535)) begin : g_divider_check
         $error("uart_rx: CLK_FREQ / BAUD_RATE must be in 4..65535");
      end
   endgenerate

   localparam logic [15:0] DIV_LAST  = 16'(DIVIDER - 1);
   localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t      state;
   logic [15:0] count;
   logic [2:0]  index;
   logic [7:0]  shift;
   logic        rx_meta;
   logic        rx_s;

   // Two-flop synchroniser; both flops rest at the idle (high) line level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_s    <= rx_meta;
      end
   end

   // Receive FSM with its counter, bit index, shift register and
   // registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         count       <= 16'd0;
         index       <= 3'd0;
         shift       <= 8'd0;
         o_data      <= 8'd0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         case (state)
            S_IDLE: begin
               count <= 16'd0;
               index <= 3'd0;
               if (!rx_s) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (count == HALF_LAST) begin
                  count <= 16'd0;
                  // A line that is high again at mid-start was a glitch.
                  state <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  count <= count + 16'd1;
               end
            end
            S_DATA: begin
               if (count == DIV_LAST) begin
                  count        <= 16'd0;
                  shift[index] <= rx_s;
                  if (index == 3'd7) begin
                     index <= 3'd0;
                     state <= S_STOP;
                  end else begin
                     index <= index + 3'd1;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end
            S_STOP: begin
               if (count == DIV_LAST) begin
                  count <= 16'd0;
                  if (rx_s) begin
                     // Return to idle mid-stop-bit so a back-to-back start
                     // edge is caught.
                     o_data  <= shift;
                     o_valid <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     o_frame_err <= 1'b1;
                     state       <= S_BREAK;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end
            S_BREAK: begin
               count <= 16'd0;
               index <= 3'd0;
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               count <= 16'd0;
               index <= 3'd0;
            end
         endcase
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule
